// File: rtl/spi_pkg.sv
// Shared definitions for the SD-card SPI master: register offsets,
// FSM state encoding and status bit positions.
package spi_pkg;

  localparam logic [1:0] SPI_DATA = 2'd0;
  localparam logic [1:0] SPI_CTL  = 2'd1;
  localparam logic [1:0] SPI_DIV  = 2'd2;

  localparam int BUSY_BIT = 7;
  localparam int SS_BIT   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_half_tick.sv
// Loadable 8-bit down-counter that times one SCLK half-period.
// tick_o is high while the count sits at zero; a load on that cycle
// restarts the next half-period, so each half-period lasts load_val+1 cycles.
module spi_half_tick (
  input  logic       phi_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       tick_o
);

  logic [7:0] cnt_q;

  // Count down to zero and hold there until reloaded.
  always_ff @(posedge phi_i) begin
    if (reset_i) begin
      cnt_q <= 8'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign tick_o = (cnt_q == 8'd0);

endmodule

// File: rtl/z80_spi_master.sv
// Byte-wide SPI mode-0 master for the SD card slot, MSB first, on the CPU
// phi clock. One OUT to the data register moves a whole byte.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer; sd_clk low, sd_mosi high, data write starts one
// LOW   | SCLK low half-period; MISO sampled as SCLK rises at its end
// HIGH  | SCLK high half-period; MOSI advances as SCLK falls at its end
module z80_spi_master
  import spi_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = 8'd23
) (
  input  logic       phi_i,
  input  logic       reset_i,
  input  logic       wr_tick_i,
  input  logic       rd_tick_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       busy_o,
  output logic       sd_clk_o,
  output logic       sd_mosi_o,
  output logic       sd_ssel_n_o,
  input  logic       sd_miso_i
);

  spi_state_e state_q;
  logic       busy_q;
  logic       sclk_q;
  logic       mosi_q;
  logic [7:0] tx_q;
  logic [7:0] rx_sh_q;
  logic [7:0] rx_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] div_q;
  logic [7:0] div_lat_q;
  logic       ss_q;

  logic       start;
  logic       tick;
  logic       cnt_load;
  logic [7:0] cnt_load_val;
  logic [7:0] rx_next;

  // Reads have no side effects today; the strobe is kept for a future done flag.
  logic unused_rd_tick;
  assign unused_rd_tick = rd_tick_i;

  // A data write only starts a transfer from IDLE; while busy it is dropped.
  assign start = wr_tick_i && (addr_i == SPI_DATA) && (state_q == IDLE);

  // Reload at transfer start with the live divider, and at every half-period
  // end with the divider latched for this byte.
  assign cnt_load     = start || ((state_q != IDLE) && tick);
  assign cnt_load_val = start ? div_q : div_lat_q;

  assign rx_next = {rx_sh_q[6:0], sd_miso_i};

  spi_half_tick u_half_tick (
    .phi_i      (phi_i),
    .reset_i    (reset_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .tick_o     (tick)
  );

  // Control and divider registers; writable at any time.
  always_ff @(posedge phi_i) begin
    if (reset_i) begin
      ss_q  <= 1'b0;
      div_q <= DIV_RESET;
    end else if (wr_tick_i) begin
      if (addr_i == SPI_CTL) ss_q  <= din_i[SS_BIT];
      if (addr_i == SPI_DIV) div_q <= din_i;
    end
  end

  // Transfer FSM with registered SPI pins and busy flag.
  always_ff @(posedge phi_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      tx_q      <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_q      <= 8'hFF;
      bit_cnt_q <= 3'd0;
      div_lat_q <= DIV_RESET;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            tx_q      <= din_i;
            mosi_q    <= din_i[7];
            bit_cnt_q <= 3'd0;
            div_lat_q <= div_q;
            busy_q    <= 1'b1;
            state_q   <= LOW;
          end
        end
        LOW: begin
          if (tick) begin
            sclk_q  <= 1'b1;
            rx_sh_q <= rx_next;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sclk_q <= 1'b0;
            if (bit_cnt_q == 3'd7) begin
              rx_q    <= rx_sh_q;
              mosi_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              tx_q      <= {tx_q[6:0], 1'b0};
              mosi_q    <= tx_q[6];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              state_q   <= LOW;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b1;
        end
      endcase
    end
  end

  // Asynchronous read mux for the IO decoder.
  always_comb begin
    dout_o = 8'hFF;
    case (addr_i)
      SPI_DATA: dout_o = rx_q;
      SPI_CTL: begin
        dout_o           = 8'h00;
        dout_o[BUSY_BIT] = busy_q;
        dout_o[SS_BIT]   = ss_q;
      end
      SPI_DIV: dout_o = div_q;
      default: dout_o = 8'hFF;
    endcase
  end

  assign busy_o      = busy_q;
  assign sd_clk_o    = sclk_q;
  assign sd_mosi_o   = mosi_q;
  assign sd_ssel_n_o = ~ss_q;

endmodule
